// File: rtl/alu_issue_ctrl.sv
// Execute-stage request scheduler: buffers ALU requests in a FIFO, issues them one at a time
// from registered operands, and returns each result/NZCV on a valid/ready channel.
module alu_issue_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             req_valid_in,
  output logic             req_ready_out,
  input  logic [31:0]      req_a_in,
  input  logic [31:0]      req_b_in,
  input  logic [3:0]       req_cmd_in,
  input  logic [1:0]       req_sh_in,
  input  logic [4:0]       req_shamt5_in,
  input  logic             req_i_in,
  input  logic             req_s_in,
  input  logic [TAG_W-1:0] req_tag_in,
  output logic [31:0]      alu_a_out,
  output logic [31:0]      alu_b_out,
  output logic [3:0]       alu_cmd_out,
  output logic [1:0]       alu_sh_out,
  output logic [4:0]       alu_shamt5_out,
  output logic             alu_i_out,
  output logic             alu_s_out,
  input  logic [31:0]      alu_result_in,
  input  logic [3:0]       alu_nzcv_in,
  output logic             res_valid_out,
  input  logic             res_ready_in,
  output logic [31:0]      res_data_out,
  output logic [3:0]       res_nzcv_out,
  output logic [TAG_W-1:0] res_tag_out,
  output logic [3:0]       flags_out,
  output logic             busy_out
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [3:0]       cmd;
    logic [1:0]       sh;
    logic [4:0]       shamt5;
    logic             i;
    logic             s;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    HOLD
  } state_t;

  state_t      state;
  req_t        mem [DEPTH];
  req_t        issue_q;
  req_t        push_data;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = req_valid_in && !full;

  // res_valid_out is always set in HOLD, so res_ready_in alone marks the handshake there.
  always_comb begin
    pop = 1'b0;
    if (!empty) begin
      if (state == IDLE)                      pop = 1'b1;
      else if (state == HOLD && res_ready_in) pop = 1'b1;
    end
  end

  always_comb begin
    push_data        = '0;
    push_data.a      = req_a_in;
    push_data.b      = req_b_in;
    push_data.cmd    = req_cmd_in;
    push_data.sh     = req_sh_in;
    push_data.shamt5 = req_shamt5_in;
    push_data.i      = req_i_in;
    push_data.s      = req_s_in;
    push_data.tag    = req_tag_in;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= IDLE;
      issue_q       <= '0;
      res_valid_out <= 1'b0;
      res_data_out  <= '0;
      res_nzcv_out  <= '0;
      res_tag_out   <= '0;
      flags_out     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            issue_q <= mem[rd_ptr];
            state   <= EXEC;
          end
        end
        EXEC: begin
          res_data_out  <= alu_result_in;
          res_nzcv_out  <= alu_nzcv_in;
          res_tag_out   <= issue_q.tag;
          res_valid_out <= 1'b1;
          if (issue_q.s) flags_out <= alu_nzcv_in;
          state <= HOLD;
        end
        HOLD: begin
          if (res_ready_in) begin
            res_valid_out <= 1'b0;
            if (!empty) begin
              issue_q <= mem[rd_ptr];
              state   <= EXEC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready_out  = !full;
  assign busy_out       = (state != IDLE) || !empty;
  assign alu_a_out      = issue_q.a;
  assign alu_b_out      = issue_q.b;
  assign alu_cmd_out    = issue_q.cmd;
  assign alu_sh_out     = issue_q.sh;
  assign alu_shamt5_out = issue_q.shamt5;
  assign alu_i_out      = issue_q.i;
  assign alu_s_out      = issue_q.s;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a small ALU stub feeds results back, a scoreboard queue holds
// expected results per accepted request, and a negedge monitor checks each handshake.
module tb_alu_issue_ctrl;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid, req_ready_out;
  logic [31:0]      req_a, req_b;
  logic [3:0]       req_cmd;
  logic [1:0]       req_sh;
  logic [4:0]       req_shamt5;
  logic             req_i, req_s;
  logic [TAG_W-1:0] req_tag;
  logic [31:0]      alu_a_out, alu_b_out;
  logic [3:0]       alu_cmd_out;
  logic [1:0]       alu_sh_out;
  logic [4:0]       alu_shamt5_out;
  logic             alu_i_out, alu_s_out;
  logic [31:0]      alu_result;
  logic [3:0]       alu_nzcv;
  logic             res_valid_out, res_ready;
  logic [31:0]      res_data_out;
  logic [3:0]       res_nzcv_out;
  logic [TAG_W-1:0] res_tag_out;
  logic [3:0]       flags_out;
  logic             busy_out;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .req_valid_in(req_valid), .req_ready_out(req_ready_out),
    .req_a_in(req_a), .req_b_in(req_b), .req_cmd_in(req_cmd), .req_sh_in(req_sh),
    .req_shamt5_in(req_shamt5), .req_i_in(req_i), .req_s_in(req_s), .req_tag_in(req_tag),
    .alu_a_out(alu_a_out), .alu_b_out(alu_b_out), .alu_cmd_out(alu_cmd_out),
    .alu_sh_out(alu_sh_out), .alu_shamt5_out(alu_shamt5_out),
    .alu_i_out(alu_i_out), .alu_s_out(alu_s_out),
    .alu_result_in(alu_result), .alu_nzcv_in(alu_nzcv),
    .res_valid_out(res_valid_out), .res_ready_in(res_ready),
    .res_data_out(res_data_out), .res_nzcv_out(res_nzcv_out), .res_tag_out(res_tag_out),
    .flags_out(flags_out), .busy_out(busy_out)
  );

  // ALU stub: cmd 0100 adds, anything else XORs; NZCV is simply B's top nibble.
  assign alu_result = (alu_cmd_out == 4'b0100) ? alu_a_out + alu_b_out : alu_a_out ^ alu_b_out;
  assign alu_nzcv   = alu_b_out[31:28];

  typedef struct {
    logic [31:0] data;
    logic [3:0]  nzcv;
    logic [3:0]  tag;
    logic        s;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  cmd;
    logic        s;
    logic [3:0]  tag;
    logic [31:0] exp_data;
    logic [3:0]  exp_nzcv;
  } vec_t;

  exp_t        sb[$];
  vec_t        tbl[5];
  int          n_vec = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          n_results = 0;
  int          prev_hs = -1;
  bit          gap_en = 1'b0;
  logic [3:0]  exp_flags = 4'b0000;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: a handshake seen at the negedge completes at the following posedge.
  always @(negedge clk) begin
    if (rst_n && res_valid_out && res_ready) begin
      exp_t e;
      n_results++;
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_result: got tag %0h data %0h expected no result", res_tag_out, res_data_out);
      end else begin
        e = sb.pop_front();
        if (e.s) exp_flags = e.nzcv;
        chk("res_data", res_data_out, e.data);
        chk("res_nzcv", {28'd0, res_nzcv_out}, {28'd0, e.nzcv});
        chk("res_tag", {28'd0, res_tag_out}, {28'd0, e.tag});
        chk("flags", {28'd0, flags_out}, {28'd0, exp_flags});
      end
      if (gap_en) begin
        if (prev_hs >= 0) chk("stream_gap", cyc - prev_hs, 2);
        prev_hs = cyc;
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] cmd,
                      input logic s, input logic [3:0] tag,
                      input logic [31:0] ed, input logic [3:0] en);
    bit ok;
    req_a = a; req_b = b; req_cmd = cmd; req_s = s; req_tag = tag;
    req_sh = tag[1:0]; req_shamt5 = {1'b0, tag}; req_i = tag[0];
    req_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (req_ready_out) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_fail++;
      $display("FAIL accept_timeout: got req_ready_out 0 expected 1 within 200 cycles (tag %0h)", tag);
    end else begin
      @(posedge clk);
      sb.push_back('{ed, en, tag, s});
      #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !res_valid_out) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s_drain: got %0d pending results expected 0", nm, sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected $finish before 200000");
    $fatal(1);
  end

  initial begin
    int start;
    logic [31:0] hd, ha;
    logic [3:0]  ht;
    bit ok;

    tbl[0] = '{32'h0000_0010, 32'h8000_0000, 4'b0100, 1'b1, 4'h1, 32'h8000_0010, 4'b1000};
    tbl[1] = '{32'h0000_0003, 32'h4000_0000, 4'b0100, 1'b0, 4'h2, 32'h4000_0003, 4'b0100};
    tbl[2] = '{32'hFF00_FF00, 32'h0F0F_0F0F, 4'b0000, 1'b1, 4'h4, 32'hF00F_F00F, 4'b0000};
    tbl[3] = '{32'hFFFF_FFFF, 32'h2000_0001, 4'b0100, 1'b1, 4'h5, 32'h2000_0000, 4'b0010};
    tbl[4] = '{32'h0000_0000, 32'h0000_0000, 4'b0010, 1'b0, 4'h6, 32'h0000_0000, 4'b0000};

    rst_n = 1'b0; req_valid = 1'b0; res_ready = 1'b1;
    req_a = '0; req_b = '0; req_cmd = '0; req_sh = '0; req_shamt5 = '0;
    req_i = 1'b0; req_s = 1'b0; req_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready_out, 1);
    chk("rst_res_valid", res_valid_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_flags", flags_out, 0);
    chk("rst_alu_a", alu_a_out, 0);
    chk("rst_res_data", res_data_out, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single add and latency: accept at edge 0, issue at edge 1, result after edge 2.
    send(32'd5, 32'd7, 4'b0100, 1'b1, 4'h3, 32'd12, 4'b0000);
    chk("lat_e0_valid", res_valid_out, 0);
    chk("lat_e0_busy", busy_out, 1);
    @(posedge clk); #1;
    chk("lat_e1_valid", res_valid_out, 0);
    chk("lat_e1_alu_a", alu_a_out, 5);
    chk("lat_e1_alu_b", alu_b_out, 7);
    chk("lat_e1_alu_cmd", alu_cmd_out, 4'b0100);
    chk("lat_e1_alu_s", alu_s_out, 1);
    chk("lat_e1_alu_shamt", alu_shamt5_out, 5'd3);
    chk("lat_e1_alu_sh", alu_sh_out, 2'd3);
    chk("lat_e1_alu_i", alu_i_out, 1);
    @(posedge clk); #1;
    chk("lat_e2_valid", res_valid_out, 1);
    chk("lat_e2_data", res_data_out, 12);
    chk("lat_e2_tag", res_tag_out, 3);
    chk("lat_e2_flags", flags_out, 0);
    wait_drain("single");
    chk("idle_busy", busy_out, 0);

    for (int i = 0; i < 5; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].cmd, tbl[i].s, tbl[i].tag, tbl[i].exp_data, tbl[i].exp_nzcv);
      wait_drain("table");
      if (i == 1) chk("flag_gate_flags", flags_out, 4'b1000);
    end

    // Backpressure: DEPTH+1 requests fill issue stage plus FIFO.
    res_ready = 1'b0;
    for (int t = 0; t <= DEPTH; t++)
      send(32'(t * 3 + 1), 32'(t << 8), 4'b0100, 1'b0, 4'(t), 32'(t * 3 + 1 + (t << 8)), 4'b0000);
    chk("bp_full_ready", req_ready_out, 0);
    chk("bp_valid", res_valid_out, 1);
    chk("bp_first_tag", res_tag_out, 0);
    hd = res_data_out; ht = res_tag_out; ha = alu_a_out;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", res_valid_out, 1);
      chk("bp_hold_data", res_data_out, hd);
      chk("bp_hold_tag", res_tag_out, ht);
      chk("bp_hold_alu_a", alu_a_out, ha);
      chk("bp_hold_ready", req_ready_out, 0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("full_pop_ready", req_ready_out, 1);
    send(32'd100, 32'd1, 4'b0100, 1'b0, 4'h5, 32'd101, 4'b0000);
    chk("refill_ready", req_ready_out, 0);
    wait_drain("bp");

    // Streaming with ready held high: one result every two cycles.
    start = n_results;
    prev_hs = -1;
    gap_en = 1'b1;
    for (int t = 0; t < 8; t++)
      send(32'(t + 16), 32'h0000_0100, 4'b0100, 1'b1, 4'(t + 8), 32'(t + 16 + 256), 4'b0000);
    wait_drain("stream");
    gap_en = 1'b0;
    chk("stream_count", n_results - start, 8);

    // Reset in HOLD with two entries queued.
    res_ready = 1'b0;
    for (int t = 0; t < 3; t++)
      send(32'(t), 32'hA000_0000, 4'b0100, 1'b1, 4'(t + 1), 32'hA000_0000 + 32'(t), 4'b1010);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (res_valid_out) begin
        ok = 1'b1;
        break;
      end
    end
    chk("mr_reached_hold", ok, 1);
    chk("mr_pre_flags", flags_out, 4'b1010);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", res_valid_out, 0);
    chk("mr_busy", busy_out, 0);
    chk("mr_flags", flags_out, 0);
    chk("mr_req_ready", req_ready_out, 1);
    chk("mr_alu_a", alu_a_out, 0);
    sb.delete();
    exp_flags = 4'b0000;
    res_ready = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    start = n_results;
    repeat (10) @(posedge clk);
    #1;
    chk("mr_no_stale", n_results - start, 0);
    chk("mr_idle_busy", busy_out, 0);
    send(32'd40, 32'd2, 4'b0100, 1'b1, 4'h9, 32'd42, 4'b0000);
    wait_drain("post_reset");
    chk("mr_post_count", n_results - start, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Request scheduler and sequencer for the 32-bit CPU ALU. Buffers operation requests in a small FIFO and issues them to the combinational ALU one at a time from registered operands. Captures each result and NZCV into a valid/ready result channel and maintains the architectural flag register, which is updated only for S-flagged operations. Sits between decode/issue and the ALU in the execute stage.

## Interface

Parameters:
- DEPTH, 4, request FIFO entries; power of two, ≥2
- TAG_W, 4, width of the opaque request tag returned with each result

Ports:
- clk_in  input  1  clock; all state updates on the rising edge
- rst_n_in  input  1  reset, asynchronous, active-low
- req_valid_in  input  1  request valid
- req_ready_out  output  1  FIFO can accept; equals !full
- req_a_in, req_b_in  input  32  operands
- req_cmd_in  input  4  ALU command
- req_sh_in  input  2  shift type
- req_shamt5_in  input  5  shift amount field
- req_i_in, req_s_in  input  1  immediate flag, set-flags flag
- req_tag_in  input  TAG_W  tag
- alu_a_out, alu_b_out  output  32  to ALU A/B
- alu_cmd_out  output  4  to ALU cmd
- alu_sh_out  output  2  to ALU sh
- alu_shamt5_out  output  5  to ALU shamt5
- alu_i_out, alu_s_out  output  1  to ALU I/S
- alu_result_in  input  32  from ALU result
- alu_nzcv_in  input  4  from ALU NZCV
- res_valid_out  output  1  result valid
- res_ready_in  input  1  consumer ready
- res_data_out  output  32  captured result
- res_nzcv_out  output  4  captured NZCV of this operation
- res_tag_out  output  TAG_W  tag of this operation
- flags_out  output  4  architectural NZCV
- busy_out  output  1  high when state ≠ IDLE or FIFO non-empty

## Operation

- FIFO: push on req_valid_in && req_ready_out; pop as defined by the FSM. Push and pop in the same cycle keeps the count unchanged. No bypass: an entry pushed into an empty FIFO is popped no earlier than the next edge. Pointers wrap modulo DEPTH.
- Issue registers hold a, b, cmd, sh, shamt5, i, s, and tag. The alu_* outputs drive directly from these registers, so the ALU inputs are stable for a whole cycle.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop into the issue registers and go to EXEC.
  - EXEC: the ALU settles. At the edge, capture alu_result_in, alu_nzcv_in, and the tag into the res_* registers and set res_valid_out. If s=1, also load flags_out from alu_nzcv_in. Go to HOLD.
  - HOLD: results are held stable while res_valid_out && !res_ready_in.
    - On handshake with the FIFO non-empty: pop and go to EXEC; res_valid_out clears.
    - On handshake with the FIFO empty: go to IDLE; res_valid_out clears.
- The issue registers change only on a pop. In HOLD, the alu_* outputs keep the last issued operation.
- The flag register changes only at EXEC capture with s=1. When s=0, res_nzcv_out still reports the ALU flags, but flags_out is untouched.
- Reset mid-operation aborts everything:
  - The FIFO empties; queued and in-flight requests are discarded with no result.
  - FSM goes to IDLE.
  - All registers clear.

## Timing

- Reset values:
  - req_ready_out=1, because the FIFO is empty.
  - res_valid_out, busy_out, and flags_out are 0.
  - All alu_* and res_* outputs are 0.
- Latency: a request accepted at edge k into an idle block is popped at edge k+1. res_valid_out rises after edge k+2.
- Throughput: one result per 2 cycles with res_ready_in held high and the FIFO fed.
- When full, req_ready_out=0. A pop at edge k raises req_ready_out after edge k, so accepting into the freed slot needs a separate, later cycle.
- res_valid_out never drops without a handshake. res_data_out, res_nzcv_out, and res_tag_out are stable while valid && !ready.
- A result may be consumed in the same cycle it becomes valid. The ready-to-valid path is purely registered.

## Test plan

- Single add: A=5, B=7, cmd=0100, S=1, tag=3, accepted at edge 0; ALU stub returns 12, NZCV=0000. Required: res_valid_out after edge 2, res_data_out=12, res_tag_out=3, flags_out=0000.
- Flag gating: an op with S=0 and stub NZCV=0100 follows an op with S=1 and NZCV=1000. Required: flags_out=1000 after both ops; the second op's res_nzcv_out=0100.
- Backpressure: push DEPTH+1 requests back-to-back with res_ready_in=0. Required:
  - req_ready_out drops once the FIFO is full.
  - The first result holds stable for 10 cycles.
  - After ready is released, all results come out in tag order 0..DEPTH with no loss.
- Streaming: 8 requests with res_ready_in=1 continuously. Required: results on every second cycle, in order.
- Simultaneous push/pop when full: at the HOLD-handshake edge, FIFO count stays at DEPTH-1 (one pop, no push), then refills on the next accepting cycle.
- Reset mid-operation: assert rst_n_in low during HOLD with 2 entries queued. Required:
  - res_valid_out=0, busy_out=0, and flags_out=0 immediately (asynchronous).
  - After release, no stale results appear and the next request completes normally.
